mips_cpu_muldiv: RTL and testbench

Parametrised multi-cycle multiply/divide unit owning the HI/LO register pair, replacing the single-cycle combinational MULT/DIV path inside the ALU. It sits beside the ALU in the execute stage. The control unit issues an operation with a one-cycle `start` pulse and stalls on `busy` until the unit finishes. HI/LO reads (MFHI/MFLO) take the `hi`/`lo` outputs directly. The signed division it produces is correct for every operand sign combination, with a defined result for divide-by-zero.

---
 rtl/mips_cpu_muldiv_if.sv | 18 +
 rtl/mips_cpu_muldiv.sv | 156 +++++++++++++++
 tb/tb_mips_cpu_muldiv.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/mips_cpu_muldiv_if.sv
// Issue/result bundle between the control unit and the multi-cycle mul/div unit.
// The control unit drives the master side; the unit owns HI/LO and drives the slave side.
interface mips_cpu_muldiv_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             flush;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (output start, flush, op, a, b, input busy, done, hi, lo);
  modport slave  (input start, flush, op, a, b, output busy, done, hi, lo);
endinterface

// File: rtl/mips_cpu_muldiv.sv
// Multi-cycle radix-2 multiply/divide unit owning the HI/LO pair: WIDTH shift-add or
// restoring shift-subtract steps on operand magnitudes, then one sign-fix/write cycle.
module mips_cpu_muldiv #(
  parameter int WIDTH = 32
) (
  input logic              clk,
  input logic              reset,
  mips_cpu_muldiv_if.slave bus
);
  localparam int CW = $clog2(WIDTH);

  localparam logic [2:0] OP_MULTU = 3'b000;
  localparam logic [2:0] OP_MULT  = 3'b001;
  localparam logic [2:0] OP_DIVU  = 3'b010;
  localparam logic [2:0] OP_DIV   = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t             state;
  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] acc;      // mul: {partial, multiplier}; div: {remainder, quotient}
  logic [WIDTH-1:0]   opnd;     // multiplicand or divisor magnitude
  logic               is_div;
  logic               neg_q;    // negate product / quotient
  logic               neg_r;    // negate remainder
  logic [WIDTH-1:0]   hi_q;
  logic [WIDTH-1:0]   lo_q;
  logic               busy_q;
  logic               done_q;

  // Operand decode for an operation being accepted this edge.
  logic             signed_op;
  logic             div_zero;
  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;

  // NOTE: every combinational output gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    signed_op = bus.op[0];
    // Divide-by-zero runs unsigned on the raw dividend: the restoring loop then yields
    // an all-ones quotient and leaves the dividend in the remainder untouched.
    div_zero  = bus.op[1] && (bus.b == '0);
    a_neg     = signed_op && bus.a[WIDTH-1] && !div_zero;
    b_neg     = signed_op && bus.b[WIDTH-1] && !div_zero;
    a_mag     = a_neg ? -bus.a : bus.a;
    b_mag     = b_neg ? -bus.b : bus.b;
  end

  // One radix-2 step of either algorithm.
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_trial;
  logic [2*WIDTH-1:0] acc_next;

  always_comb begin
    mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? opnd : '0)};
    div_trial = acc[2*WIDTH-1:WIDTH-1] - {1'b0, opnd};
    acc_next  = {mul_sum, acc[WIDTH-1:1]};
    if (is_div) begin
      acc_next = div_trial[WIDTH] ? {acc[2*WIDTH-2:0], 1'b0}
                                  : {div_trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
    end
  end

  // Sign-corrected results presented to HI/LO in FIX.
  logic [2*WIDTH-1:0] product;
  logic [WIDTH-1:0]   quot;
  logic [WIDTH-1:0]   rem;

  always_comb begin
    product = neg_q ? -acc : acc;
    quot    = neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    rem     = neg_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= '0;
      acc    <= '0;
      opnd   <= '0;
      is_div <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      hi_q   <= '0;
      lo_q   <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (bus.flush) begin
        state  <= IDLE;
        busy_q <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (bus.start && !busy_q) begin
              case (bus.op)
                OP_MTHI: hi_q <= bus.a;
                OP_MTLO: lo_q <= bus.a;
                OP_MULTU, OP_MULT: begin
                  acc    <= {{WIDTH{1'b0}}, b_mag};
                  opnd   <= a_mag;
                  is_div <= 1'b0;
                  neg_q  <= a_neg ^ b_neg;
                  neg_r  <= 1'b0;
                  cnt    <= '0;
                  busy_q <= 1'b1;
                  state  <= CALC;
                end
                OP_DIVU, OP_DIV: begin
                  acc    <= {{WIDTH{1'b0}}, a_mag};
                  opnd   <= b_mag;
                  is_div <= 1'b1;
                  neg_q  <= a_neg ^ b_neg;
                  neg_r  <= a_neg;
                  cnt    <= '0;
                  busy_q <= 1'b1;
                  state  <= CALC;
                end
                default: ;
              endcase
            end
          end
          CALC: begin
            acc <= acc_next;
            cnt <= cnt + CW'(1);
            if (cnt == CW'(WIDTH - 1)) state <= FIX;
          end
          FIX: begin
            if (is_div) begin
              hi_q <= rem;
              lo_q <= quot;
            end else begin
              hi_q <= product[2*WIDTH-1:WIDTH];
              lo_q <= product[WIDTH-1:0];
            end
            busy_q <= 1'b0;
            done_q <= 1'b1;
            state  <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;
endmodule

// File: tb/tb_mips_cpu_muldiv.sv
// Scoreboard bench for mips_cpu_muldiv (WIDTH=32): expected HI/LO pairs are queued at
// issue and compared by a monitor whenever done pulses; tasks check timing and side cases.
module tb_mips_cpu_muldiv;
  localparam int W = 32;

  localparam logic [2:0] OP_MULTU = 3'b000;
  localparam logic [2:0] OP_MULT  = 3'b001;
  localparam logic [2:0] OP_DIVU  = 3'b010;
  localparam logic [2:0] OP_DIV   = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

  typedef struct {
    string        name;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
  } exp_t;

  logic clk;
  logic reset;
  mips_cpu_muldiv_if #(.WIDTH(W)) bus ();

  mips_cpu_muldiv #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  exp_t         sb[$];
  int           checks   = 0;
  int           failures = 0;
  logic [W-1:0] exp_hi   = '0;
  logic [W-1:0] exp_lo   = '0;

  // Monitor: every done pulse must match the oldest queued result.
  always @(negedge clk) begin
    if (!reset && bus.done === 1'b1) begin
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL unexpected_done hi=%h lo=%h with no operation outstanding", bus.hi, bus.lo);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (bus.hi !== e.hi || bus.lo !== e.lo) begin
          failures++;
          $display("FAIL %s got hi=%h lo=%h expected hi=%h lo=%h", e.name, bus.hi, bus.lo, e.hi, e.lo);
        end
        exp_hi = e.hi;
        exp_lo = e.lo;
      end
    end
  end

  // Drive one start pulse so the next rising edge is the accepting edge.
  task automatic issue(input logic [2:0] o, input logic [W-1:0] av, input logic [W-1:0] bv);
    bus.start = 1'b1;
    bus.op    = o;
    bus.a     = av;
    bus.b     = bv;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  // Count busy cycles up to the done cycle, watching that HI/LO stay frozen meanwhile.
  task automatic wait_done(output int cycles, output bit stable);
    cycles = 0;
    stable = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus.busy !== 1'b1) break;
      cycles++;
      if (bus.hi !== exp_hi || bus.lo !== exp_lo) stable = 1'b0;
    end
  endtask

  // Full mul/div transaction; returns in the done cycle so the caller may issue back-to-back.
  task automatic run_op(input string name, input logic [2:0] o, input logic [W-1:0] av,
                        input logic [W-1:0] bv, input logic [W-1:0] ehi, input logic [W-1:0] elo);
    int cycles;
    bit stable;
    sb.push_back('{name, ehi, elo});
    issue(o, av, bv);
    wait_done(cycles, stable);
    checks++;
    if (cycles != W + 1) begin
      failures++;
      $display("FAIL %s_busy_cycles got %0d expected %0d", name, cycles, W + 1);
    end
    checks++;
    if (!stable) begin
      failures++;
      $display("FAIL %s_hilo_stable hi/lo changed while busy (expected hi=%h lo=%h)", name, exp_hi, exp_lo);
    end
    checks++;
    if (bus.done !== 1'b1) begin
      failures++;
      $display("FAIL %s_done got %b expected 1", name, bus.done);
    end
  endtask

  task automatic test_reset;
    reset     = 1'b1;
    bus.start = 1'b0;
    bus.flush = 1'b0;
    bus.op    = '0;
    bus.a     = '0;
    bus.b     = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.hi !== '0 || bus.lo !== '0 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      failures++;
      $display("FAIL reset_state got hi=%h lo=%h busy=%b done=%b expected all zero",
               bus.hi, bus.lo, bus.busy, bus.done);
    end
  endtask

  task automatic test_multu;
    run_op("multu_max", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
    @(negedge clk);
    checks++;
    if (bus.done !== 1'b0) begin
      failures++;
      $display("FAIL done_one_cycle got done=%b expected 0", bus.done);
    end
  endtask

  task automatic test_back_to_back;
    @(negedge clk);
    run_op("mult_neg", OP_MULT, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1);
    run_op("div_b2b", OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op("mult_minmin", OP_MULT, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000);
  endtask

  task automatic test_div_corner;
    run_op("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000);
    run_op("divu_zero", OP_DIVU, 32'h0000_1234, 32'd0, 32'h0000_1234, 32'hFFFF_FFFF);
    run_op("div_zero_neg", OP_DIV, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, 32'hFFFF_FFFF);
    run_op("div_pos_neg", OP_DIV, 32'd7, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD);
  endtask

  task automatic test_move;
    int  cycles;
    bit  stable;
    @(negedge clk);
    issue(OP_MTHI, 32'hCAFE_F00D, 32'd0);
    checks++;
    if (bus.hi !== 32'hCAFE_F00D || bus.busy !== 1'b0) begin
      failures++;
      $display("FAIL mthi got hi=%h busy=%b expected hi=cafef00d busy=0", bus.hi, bus.busy);
    end
    exp_hi = 32'hCAFE_F00D;
    // MTLO issued while a DIVU is busy must vanish.
    @(negedge clk);
    sb.push_back('{"divu_mtlo_ignored", 32'd6, 32'd142});
    issue(OP_DIVU, 32'd1000, 32'd7);
    repeat (3) @(negedge clk);
    issue(OP_MTLO, 32'hDEAD_BEEF, 32'd0);
    wait_done(cycles, stable);
    checks++;
    if (!stable || bus.done !== 1'b1) begin
      failures++;
      $display("FAIL mtlo_while_busy hi/lo stable=%b done=%b expected stable=1 done=1", stable, bus.done);
    end
    // MTLO in the done cycle is accepted.
    issue(OP_MTLO, 32'h0000_0055, 32'd0);
    checks++;
    if (bus.lo !== 32'h0000_0055 || bus.busy !== 1'b0) begin
      failures++;
      $display("FAIL mtlo_in_done got lo=%h busy=%b expected lo=00000055 busy=0", bus.lo, bus.busy);
    end
    exp_lo = 32'h0000_0055;
    // Reserved op code changes nothing.
    @(negedge clk);
    issue(3'b110, 32'h1111_1111, 32'h2222_2222);
    @(negedge clk);
    checks++;
    if (bus.hi !== 32'd6 || bus.lo !== 32'h0000_0055 || bus.busy !== 1'b0) begin
      failures++;
      $display("FAIL reserved_op got hi=%h lo=%h busy=%b expected hi=00000006 lo=00000055 busy=0",
               bus.hi, bus.lo, bus.busy);
    end
  endtask

  task automatic test_flush;
    bit saw_done;
    @(negedge clk);
    issue(OP_MULTU, 32'd7, 32'd6);
    repeat (9) @(posedge clk);
    #1 bus.flush = 1'b1;
    @(posedge clk);
    #1 bus.flush = 1'b0;
    checks++;
    if (bus.busy !== 1'b0 || bus.hi !== 32'd6 || bus.lo !== 32'h0000_0055) begin
      failures++;
      $display("FAIL flush_mid got busy=%b hi=%h lo=%h expected busy=0 hi=00000006 lo=00000055",
               bus.busy, bus.hi, bus.lo);
    end
    saw_done = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (bus.done === 1'b1) saw_done = 1'b1;
    end
    checks++;
    if (saw_done) begin
      failures++;
      $display("FAIL flush_no_done got done pulse expected none");
    end
    // Flush on the FIX edge suppresses the write.
    issue(OP_MULTU, 32'd3, 32'd3);
    repeat (W) @(posedge clk);
    #1 bus.flush = 1'b1;
    @(posedge clk);
    #1 bus.flush = 1'b0;
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.hi !== 32'd6 || bus.lo !== 32'h0000_0055) begin
      failures++;
      $display("FAIL flush_fix got busy=%b done=%b hi=%h lo=%h expected 0 0 00000006 00000055",
               bus.busy, bus.done, bus.hi, bus.lo);
    end
    // Flush wins over start on the same edge.
    @(negedge clk);
    bus.flush = 1'b1;
    issue(OP_MTHI, 32'h7777_7777, 32'd0);
    bus.flush = 1'b0;
    checks++;
    if (bus.busy !== 1'b0 || bus.hi !== 32'd6) begin
      failures++;
      $display("FAIL flush_priority got busy=%b hi=%h expected busy=0 hi=00000006", bus.busy, bus.hi);
    end
    @(negedge clk);
    run_op("multu_reissue", OP_MULTU, 32'd7, 32'd6, 32'd0, 32'd42);
  endtask

  task automatic test_reset_mid;
    @(negedge clk);
    issue(OP_DIVU, 32'd5000, 32'd3);
    repeat (5) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    checks++;
    if (bus.hi !== '0 || bus.lo !== '0 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      failures++;
      $display("FAIL reset_async got hi=%h lo=%h busy=%b done=%b expected all zero",
               bus.hi, bus.lo, bus.busy, bus.done);
    end
    exp_hi = '0;
    exp_lo = '0;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    run_op("divu_after_reset", OP_DIVU, 32'd100, 32'd7, 32'd2, 32'd14);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_multu();
    test_back_to_back();
    test_div_corner();
    test_move();
    test_flush();
    test_reset_mid();
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain got %0d outstanding results expected 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
